fetch_stage: RTL and testbench

//  Instruction-fetch stage feeding the F->D pipeline register: owns the PC, drives a
//  one-outstanding SRAM-like instruction port, and presents pcF/pcplus4F/instrF/
//  is_in_delayslot_iF. Buffers a returned instruction while decode is stalled, applies

---
 rtl/fetch_stage.sv | 239 +++++++++++++++++++++++
 tb/tb_fetch_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage that feeds the F->D pipeline register. It owns the
// program counter, drives a single-outstanding SRAM-like instruction port and
// presents the fetched instruction together with its PC to decode.
//
// Responsibilities:
//   * Issue one request at a time at pcF and wait for the reply.
//   * Buffer a returned instruction while decode is stalled, so the reply is
//     never lost and no new request is issued until decode takes it.
//   * Steer the PC after the delay slot: a taken branch in D redirects the
//     instruction that follows the one currently in F. If the branch resolves
//     before F has an instruction, the target is parked until the handoff.
//   * Exception/eret redirects take effect immediately. A request that is
//     already in flight is marked cancelled and its reply is thrown away.
//
// Ports:
//   clk                 clock, all state changes on the rising edge
//   rst                 synchronous active-high reset
//   stallD              decode stalled, F->D register holds
//   is_branch_D         instruction in D is a branch/jump
//   branch_taken_i      branch in D is taken (only honoured when ~stallD)
//   branch_target_i     taken-branch target
//   except_redirect_i   one-cycle exception/eret redirect pulse
//   except_pc_i         redirect PC
//   inst_req            instruction request
//   inst_addr           request address (always pcF)
//   inst_addr_ok        request accepted this cycle
//   inst_data_ok        reply data valid this cycle
//   inst_rdata          reply data
//   pcF / pcplus4F      PC of the F instruction and PC+4
//   instrF              F instruction, zero when F holds nothing valid
//   is_in_delayslot_iF  F instruction sits in the delay slot of D's branch
//   fetch_stall_o       F has no valid instruction this cycle
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallD,
    input  logic        is_branch_D,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        except_redirect_i,
    input  logic [31:0] except_pc_i,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] pcF,
    output logic [31:0] pcplus4F,
    output logic [31:0] instrF,
    output logic        is_in_delayslot_iF,
    output logic        fetch_stall_o
);

    // Fetch controller states.
    //   ST_REQ  : request presented at pcF, waiting for acceptance
    //   ST_WAIT : request accepted, waiting for the reply
    //   ST_HOLD : reply captured in the buffer, waiting for decode to take it
    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]  state_reg,    state_next;
    logic [31:0] pc_reg,       pc_next;
    logic [31:0] buffer_reg,   buffer_next;
    logic        cancel_reg,   cancel_next;
    logic        pend_br_reg,  pend_br_next;
    logic [31:0] pend_tgt_reg, pend_tgt_next;

    logic        in_req;
    logic        in_wait;
    logic        in_hold;
    logic        reply_live;
    logic        valid_f;
    logic        handoff;
    logic        br_live;
    logic [31:0] seq_pc;
    logic [31:0] handoff_pc;

    // ------------------------------------------------------------------
    // Status decode
    // ------------------------------------------------------------------
    assign in_req  = (state_reg == ST_REQ);
    assign in_wait = (state_reg == ST_WAIT);
    assign in_hold = (state_reg == ST_HOLD);

    // A reply only counts if it answers a request that was not cancelled.
    assign reply_live = in_wait & inst_data_ok & ~cancel_reg;

    // F is valid when a live reply arrives or a buffered one is waiting.
    // Reset and a redirect in the same cycle suppress it so nothing is
    // handed to decode on those cycles.
    assign valid_f = ~rst & ~except_redirect_i & (reply_live | in_hold);

    // Decode captures the F instruction on this edge.
    assign handoff = valid_f & ~stallD;

    // A branch outcome from D is only meaningful while D advances.
    assign br_live = branch_taken_i & ~stallD;

    assign seq_pc = pc_reg + 32'd4;

    // PC of the instruction after the one being handed off. A parked
    // branch target wins over a branch resolving this cycle; both win
    // over sequential flow.
    always_comb begin
        handoff_pc = seq_pc;
        if (pend_br_reg) begin
            handoff_pc = pend_tgt_reg;
        end else if (br_live) begin
            handoff_pc = branch_target_i;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        buffer_next   = buffer_reg;
        cancel_next   = cancel_reg;
        pend_br_next  = pend_br_reg;
        pend_tgt_next = pend_tgt_reg;

        if (except_redirect_i) begin
            // Redirect overrides every branch decision, including a parked
            // one, and moves the PC right away.
            pc_next      = except_pc_i;
            pend_br_next = 1'b0;
            case (state_reg)
                ST_REQ: begin
                    // An accepted request now belongs to the old path; its
                    // reply must be discarded when it arrives.
                    if (inst_addr_ok) begin
                        state_next  = ST_WAIT;
                        cancel_next = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (inst_data_ok) begin
                        // The outstanding reply is here and simply dropped.
                        state_next  = ST_REQ;
                        cancel_next = 1'b0;
                    end else begin
                        // Still one reply in flight; one cancel covers it
                        // even if it was already set by an earlier redirect.
                        cancel_next = 1'b1;
                    end
                end
                default: begin
                    // Buffered instruction belongs to the old path.
                    state_next = ST_REQ;
                end
            endcase
        end else begin
            case (state_reg)
                ST_REQ: begin
                    if (inst_addr_ok) begin
                        state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (inst_data_ok) begin
                        if (cancel_reg) begin
                            // Stale reply: pcF already holds the redirect PC.
                            state_next  = ST_REQ;
                            cancel_next = 1'b0;
                        end else if (stallD) begin
                            state_next  = ST_HOLD;
                            buffer_next = inst_rdata;
                        end else begin
                            state_next = ST_REQ;
                            pc_next    = handoff_pc;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stallD) begin
                        state_next = ST_REQ;
                        pc_next    = handoff_pc;
                    end
                end
                default: begin
                    state_next = ST_REQ;
                end
            endcase

            // A branch that resolves before F has its delay-slot
            // instruction is parked and applied at the handoff.
            if (handoff) begin
                pend_br_next = 1'b0;
            end else if (br_live) begin
                pend_br_next  = 1'b1;
                pend_tgt_next = branch_target_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_REQ;
            pc_reg       <= RESET_PC;
            buffer_reg   <= 32'd0;
            cancel_reg   <= 1'b0;
            pend_br_reg  <= 1'b0;
            pend_tgt_reg <= 32'd0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            buffer_reg   <= buffer_next;
            cancel_reg   <= cancel_next;
            pend_br_reg  <= pend_br_next;
            pend_tgt_reg <= pend_tgt_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // inst_addr only moves while requesting on a redirect, so the address
    // seen by the memory is stable until it is accepted.
    assign inst_req           = ~rst & in_req;
    assign inst_addr          = pc_reg;
    assign pcF                = pc_reg;
    assign pcplus4F           = seq_pc;
    assign instrF             = valid_f ? (in_hold ? buffer_reg : inst_rdata) : 32'd0;
    assign is_in_delayslot_iF = is_branch_D & valid_f;
    assign fetch_stall_o      = ~valid_f;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Drives fetch_stage with a small memory model that answers each accepted
// request after a programmable delay. Expected outputs come from a
// transaction-level reference: the next program-order PC, whether a request
// is in flight (and stale), whether a reply is waiting for decode, and a
// parked branch target. The instruction at any PC is a fixed hash of the PC.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC   = 32'hbfc0_0000;
    localparam logic [31:0] FORCE_WORD = 32'h1234_5678;

    logic        clk;
    logic        rst;
    logic        stallD;
    logic        is_branch_D;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        except_redirect_i;
    logic [31:0] except_pc_i;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] pcF;
    logic [31:0] pcplus4F;
    logic [31:0] instrF;
    logic        is_in_delayslot_iF;
    logic        fetch_stall_o;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk                (clk),
        .rst                (rst),
        .stallD             (stallD),
        .is_branch_D        (is_branch_D),
        .branch_taken_i     (branch_taken_i),
        .branch_target_i    (branch_target_i),
        .except_redirect_i  (except_redirect_i),
        .except_pc_i        (except_pc_i),
        .inst_req           (inst_req),
        .inst_addr          (inst_addr),
        .inst_addr_ok       (inst_addr_ok),
        .inst_data_ok       (inst_data_ok),
        .inst_rdata         (inst_rdata),
        .pcF                (pcF),
        .pcplus4F           (pcplus4F),
        .instrF             (instrF),
        .is_in_delayslot_iF (is_in_delayslot_iF),
        .fetch_stall_o      (fetch_stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Memory model state
    bit          s_busy;
    int          s_cnt;
    int          s_delay;
    logic [31:0] s_addr;
    bit          want_aok;
    bit          force_en;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_inflight;
    bit          m_stale;
    bit          m_got;
    bit          m_pend;
    logic [31:0] m_ptgt;

    // Observations for directed checks
    logic [31:0] acc_q[$];
    logic [31:0] ho_q[$];
    logic        obs_ds;
    logic        obs_stall;
    logic [31:0] obs_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9e37_79b1) ^ 32'h0f0f_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: present slave outputs, check DUT outputs against the
    // reference, then advance reference and slave on the rising edge.
    task automatic step();
        bit          exp_req, dvalid, exp_valid, accepted, handoff, req_s;
        logic [31:0] exp_instr, addr_s;
        inst_data_ok = s_busy && (s_cnt == 0);
        inst_rdata   = inst_data_ok ? (force_en ? FORCE_WORD : mem_word(s_addr)) : 32'hdead_beef;
        inst_addr_ok = want_aok && !s_busy;
        #1;
        exp_req   = !rst && !m_inflight && !m_got;
        dvalid    = inst_data_ok && m_inflight;
        exp_valid = !rst && !except_redirect_i && ((dvalid && !m_stale) || m_got);
        exp_instr = exp_valid ? mem_word(m_pc) : 32'd0;
        chk("inst_req", {31'd0, inst_req}, {31'd0, exp_req});
        if (exp_req) chk("inst_addr", inst_addr, m_pc);
        if (!rst) begin
            chk("pcF", pcF, m_pc);
            chk("pcplus4F", pcplus4F, m_pc + 32'd4);
        end
        chk("instrF", instrF, exp_instr);
        chk("fetch_stall_o", {31'd0, fetch_stall_o}, {31'd0, !exp_valid});
        chk("delayslot", {31'd0, is_in_delayslot_iF}, {31'd0, exp_valid && is_branch_D});
        if (!fetch_stall_o && !stallD) ho_q.push_back(pcF);
        obs_ds    = is_in_delayslot_iF;
        obs_stall = fetch_stall_o;
        obs_instr = instrF;
        req_s     = inst_req;
        addr_s    = inst_addr;
        accepted  = exp_req && inst_addr_ok;
        handoff   = exp_valid && !stallD;
        @(posedge clk);
        if (rst) begin
            m_pc = RESET_PC; m_inflight = 0; m_stale = 0; m_got = 0; m_pend = 0;
        end else if (except_redirect_i) begin
            m_pc = except_pc_i; m_pend = 0; m_got = 0;
            if (accepted) begin
                m_inflight = 1; m_stale = 1;
            end else if (m_inflight && !dvalid) begin
                m_stale = 1;
            end else if (m_inflight) begin
                m_inflight = 0; m_stale = 0;
            end
        end else if (handoff) begin
            m_pc = m_pend ? m_ptgt : (branch_taken_i ? branch_target_i : m_pc + 32'd4);
            m_pend = 0; m_got = 0; m_inflight = 0;
        end else begin
            if (accepted) begin
                m_inflight = 1; m_stale = 0;
            end else if (dvalid) begin
                if (!m_stale) m_got = 1;
                m_inflight = 0; m_stale = 0;
            end
            if (branch_taken_i && !stallD) begin
                m_pend = 1; m_ptgt = branch_target_i;
            end
        end
        if (s_busy) begin
            if (s_cnt == 0) s_busy = 0;
            else s_cnt--;
        end
        if (req_s && inst_addr_ok) begin
            s_busy = 1; s_addr = addr_s; s_cnt = s_delay - 1;
            acc_q.push_back(addr_s);
        end
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        stallD = 0; is_branch_D = 0; branch_taken_i = 0; branch_target_i = 32'd0;
        except_redirect_i = 0; except_pc_i = 32'd0; want_aok = 1; force_en = 0;
    endtask

    task automatic clear_q();
        acc_q.delete();
        ho_q.delete();
    endtask

    initial begin
        logic [31:0] r;
        rst = 1; quiet_inputs();
        s_busy = 0; s_cnt = 0; s_delay = 1; s_addr = 32'd0;
        m_pc = RESET_PC; m_inflight = 0; m_stale = 0; m_got = 0; m_pend = 0; m_ptgt = 32'd0;
        inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 32'd0;
        @(negedge clk);

        // 1: reset then back-to-back fetches, one handoff every two cycles
        step(); step();
        rst = 0; clear_q();
        repeat (6) step();
        chk("t1_first_addr", acc_q[0], 32'hbfc0_0000);
        chk("t1_ho0", ho_q[0], 32'hbfc0_0000);
        chk("t1_ho1", ho_q[1], 32'hbfc0_0004);
        chk("t1_ho2", ho_q[2], 32'hbfc0_0008);
        chk("t1_pcF", pcF, 32'hbfc0_000c);
        chk("t1_pcplus4", pcplus4F, 32'hbfc0_0010);

        // 2: reply arrives while decode is stalled -> held, then handed off
        clear_q();
        step();
        stallD = 1;
        step(); step(); step();
        chk("t2_hold_instr", instrF, mem_word(32'hbfc0_000c));
        chk("t2_no_req", {31'd0, inst_req}, 32'd0);
        chk("t2_no_handoff", 32'(ho_q.size()), 32'd0);
        stallD = 0;
        step();
        chk("t2_handoff", ho_q[0], 32'hbfc0_000c);
        chk("t2_single_req", 32'(acc_q.size()), 32'd1);

        // 3: taken branch in D while its delay slot is fetched
        clear_q();
        is_branch_D = 1;
        step();
        branch_taken_i = 1; branch_target_i = 32'hbfc0_0100;
        step();
        chk("t3_delay_slot", {31'd0, obs_ds}, 32'd1);
        chk("t3_ds_pc", ho_q[0], 32'hbfc0_0010);
        quiet_inputs();
        step();
        chk("t3_target_req", acc_q[1], 32'hbfc0_0100);

        // 4: branch resolves while F has nothing valid -> parked target
        clear_q();
        step();
        is_branch_D = 1; branch_taken_i = 1; branch_target_i = 32'hbfc0_0200;
        step();
        chk("t4_stall_at_branch", {31'd0, obs_stall}, 32'd1);
        quiet_inputs();
        step(); step();
        chk("t4_ho_slot", ho_q[1], 32'hbfc0_0104);
        chk("t4_target_req", acc_q[1], 32'hbfc0_0200);

        // 5: exception redirect while waiting; stale reply is dropped
        clear_q();
        step();
        s_delay = 3;
        step();
        s_delay = 1;
        except_redirect_i = 1; except_pc_i = 32'hbfc0_0380;
        step();
        quiet_inputs();
        step();
        force_en = 1;
        step();
        chk("t5_dropped_instr", obs_instr, 32'd0);
        chk("t5_stall", {31'd0, obs_stall}, 32'd1);
        force_en = 0;
        step();
        chk("t5_redirect_req", acc_q[1], 32'hbfc0_0380);
        chk("t5_handoffs", 32'(ho_q.size()), 32'd1);

        // 6: reset while waiting; late reply after release is ignored
        clear_q();
        step();
        s_delay = 3;
        step();
        s_delay = 1;
        rst = 1;
        step();
        rst = 0;
        step(); step(); step();
        chk("t6_restart_req", acc_q[1], RESET_PC);
        chk("t6_handoffs", 32'(ho_q.size()), 32'd1);

        // Randomised traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            rst               = ($urandom_range(0, 299) == 0);
            stallD            = ($urandom_range(0, 2) == 0);
            is_branch_D       = ($urandom_range(0, 1) == 1);
            branch_taken_i    = is_branch_D && !stallD && ($urandom_range(0, 1) == 1);
            r                 = $urandom();
            branch_target_i   = r & 32'hffff_fffc;
            except_redirect_i = ($urandom_range(0, 24) == 0);
            r                 = $urandom();
            except_pc_i       = r & 32'hffff_fffc;
            want_aok          = ($urandom_range(0, 3) != 0);
            s_delay           = $urandom_range(1, 3);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
